// File: rtl/fetch_bus_arbiter.sv
// fetch_bus_arbiter: shares one single-port word bus between IF fetch and MEM data.
// Data wins by default; fetch is forced in after STARVE_LIMIT back-to-back data grants.
module fetch_bus_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_flush,
   output logic        if_ready,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [3:0]  dm_be,
   output logic        dm_ready,
   output logic [31:0] dm_rdata,
   output logic        dm_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      IF_BUSY,
      DM_BUSY,
      IF_DROP,
      IF_FAULT
   } state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic [TW-1:0]   timer_q, timer_d;

   logic            dm_win, if_win, if_mis, expired;
   logic            dm_addr_unused;

   logic            if_ready_d, if_err_d;
   logic [31:0]     if_rdata_d;
   logic            dm_ready_d, dm_err_d;
   logic [31:0]     dm_rdata_d;
   logic            mem_req_d, mem_we_d;
   logic [31:0]     mem_addr_d, mem_wdata_d;
   logic [3:0]      mem_be_d;

   assign dm_win  = dm_req && (!if_req || (starve_q < STARVE_MAX));
   assign if_win  = !dm_win && if_req && !if_flush;
   assign if_mis  = |if_addr[1:0];
   assign expired = (timer_q == TIMER_LAST);
   assign dm_addr_unused = ^dm_addr[1:0];

   // State, counters and every output are registered here
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         starve_q  <= '0;
         timer_q   <= '0;
         if_ready  <= 1'b0;
         if_rdata  <= '0;
         if_err    <= 1'b0;
         dm_ready  <= 1'b0;
         dm_rdata  <= '0;
         dm_err    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
      end else begin
         state_q   <= state_d;
         starve_q  <= starve_d;
         timer_q   <= timer_d;
         if_ready  <= if_ready_d;
         if_rdata  <= if_rdata_d;
         if_err    <= if_err_d;
         dm_ready  <= dm_ready_d;
         dm_rdata  <= dm_rdata_d;
         dm_err    <= dm_err_d;
         mem_req   <= mem_req_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         mem_be    <= mem_be_d;
      end
   end

   // Next state: arbitration, ack/flush/timeout handling, starve and timer counters
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      timer_d  = timer_q;
      unique case (state_q)
         IDLE: begin
            if (dm_win) begin
               state_d  = DM_BUSY;
               timer_d  = '0;
               starve_d = if_req ? starve_q + SW'(1) : '0;
            end else if (if_win) begin
               state_d  = if_mis ? IF_FAULT : IF_BUSY;
               timer_d  = '0;
               starve_d = '0;
            end
         end
         IF_BUSY: begin
            if (mem_ack) begin
               state_d = IDLE;
            end else if (if_flush) begin
               state_d = IF_DROP;
               timer_d = '0;
            end else if (expired) begin
               state_d = IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         DM_BUSY, IF_DROP: begin
            if (mem_ack || expired) begin
               state_d = IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         IF_FAULT: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Next output values: bus fields on grant, ready/rdata/err pulses on completion
   always_comb begin
      if_ready_d  = 1'b0;
      if_rdata_d  = '0;
      if_err_d    = 1'b0;
      dm_ready_d  = 1'b0;
      dm_rdata_d  = '0;
      dm_err_d    = 1'b0;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      mem_be_d    = mem_be;
      mem_req_d   = (state_d == IF_BUSY) || (state_d == DM_BUSY) ||
                    (state_d == IF_DROP);
      unique case (state_q)
         IDLE: begin
            if (dm_win) begin
               mem_we_d    = dm_we;
               mem_addr_d  = {dm_addr[31:2], 2'b00};
               mem_wdata_d = dm_wdata;
               mem_be_d    = dm_be;
            end else if (if_win && !if_mis) begin
               mem_we_d   = 1'b0;
               mem_addr_d = {if_addr[31:2], 2'b00};
               mem_be_d   = 4'hF;
            end
         end
         IF_BUSY: begin
            if (mem_ack) begin
               if (!if_flush) begin
                  if_ready_d = 1'b1;
                  if_rdata_d = mem_rdata;
               end
            end else if (!if_flush && expired) begin
               if_ready_d = 1'b1;
               if_err_d   = 1'b1;
            end
         end
         DM_BUSY: begin
            if (mem_ack) begin
               dm_ready_d = 1'b1;
               dm_rdata_d = mem_we ? 32'h0 : mem_rdata;
            end else if (expired) begin
               dm_ready_d = 1'b1;
               dm_err_d   = 1'b1;
            end
         end
         IF_FAULT: begin
            if (!if_flush) begin
               if_ready_d = 1'b1;
               if_err_d   = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fetch_bus_arbiter.sv
// tb_fetch_bus_arbiter: directed scenarios plus random traffic for fetch_bus_arbiter.
// A transaction-level reference model predicts every registered output each cycle.
module tb_fetch_bus_arbiter;

   localparam int SL = 4;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, if_flush;
   logic [31:0] if_addr;
   logic        if_ready, if_err;
   logic [31:0] if_rdata;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic [3:0]  dm_be;
   logic        dm_ready, dm_err;
   logic [31:0] dm_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   fetch_bus_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_be(dm_be),
      .dm_ready(dm_ready), .dm_rdata(dm_rdata), .dm_err(dm_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reference model: one outstanding bus transaction record
   bit          m_busy, m_fetch, m_drop, m_fault;
   int          m_age, m_starve;
   logic [31:0] m_addr, m_wdata;
   logic        m_we;
   logic [3:0]  m_be;

   logic        e_if_ready, e_if_err, e_dm_ready, e_dm_err, e_mem_req;
   logic [31:0] e_if_rdata, e_dm_rdata;
   bit          e_chk_all;

   // bus responder and requester state
   bit          dir_mode;
   int          dir_wait;
   logic [31:0] dir_data;
   int          bus_wait;
   bit          f_out, d_out;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_eval();
      e_if_ready = 0; e_if_err = 0; e_if_rdata = 0;
      e_dm_ready = 0; e_dm_err = 0; e_dm_rdata = 0;
      e_chk_all  = 0;
      if (reset) begin
         m_busy = 0; m_fetch = 0; m_drop = 0; m_fault = 0;
         m_age = 0; m_starve = 0;
         m_addr = 0; m_wdata = 0; m_we = 0; m_be = 0;
         e_chk_all = 1;
      end else if (m_fault) begin
         m_fault = 0;
         if (!if_flush) begin
            e_if_ready = 1; e_if_err = 1;
         end
      end else if (m_busy) begin
         if (mem_ack) begin
            m_busy = 0;
            if (!m_fetch) begin
               e_dm_ready = 1;
               e_dm_rdata = m_we ? 32'h0 : mem_rdata;
            end else if (!m_drop && !if_flush) begin
               e_if_ready = 1;
               e_if_rdata = mem_rdata;
            end
         end else if (m_fetch && !m_drop && if_flush) begin
            m_drop = 1;
            m_age  = 0;
         end else if (m_age == TO - 1) begin
            m_busy = 0;
            if (!m_fetch) begin
               e_dm_ready = 1; e_dm_err = 1;
            end else if (!m_drop) begin
               e_if_ready = 1; e_if_err = 1;
            end
         end else begin
            m_age++;
         end
      end else begin
         if (dm_req && (!if_req || m_starve < SL)) begin
            m_busy = 1; m_fetch = 0; m_drop = 0; m_age = 0;
            m_addr = {dm_addr[31:2], 2'b00};
            m_we = dm_we; m_wdata = dm_wdata; m_be = dm_be;
            m_starve = if_req ? ((m_starve + 1 > SL) ? SL : m_starve + 1) : 0;
         end else if (if_req && !if_flush) begin
            m_starve = 0;
            if (if_addr[1:0] != 2'b00) begin
               m_fault = 1;
            end else begin
               m_busy = 1; m_fetch = 1; m_drop = 0; m_age = 0;
               m_addr = {if_addr[31:2], 2'b00};
               m_we = 0; m_be = 4'hF;
            end
         end
      end
      e_mem_req = m_busy;
   endtask

   task automatic check_outputs();
      chk("if_ready", 32'(if_ready), 32'(e_if_ready));
      chk("if_err", 32'(if_err), 32'(e_if_err));
      chk("if_rdata", if_rdata, e_if_rdata);
      chk("dm_ready", 32'(dm_ready), 32'(e_dm_ready));
      chk("dm_err", 32'(dm_err), 32'(e_dm_err));
      chk("dm_rdata", dm_rdata, e_dm_rdata);
      chk("mem_req", 32'(mem_req), 32'(e_mem_req));
      chk("ready_excl", 32'(if_ready & dm_ready), 32'h0);
      if (e_mem_req || e_chk_all) begin
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_we", 32'(mem_we), 32'(m_we));
         chk("mem_be", 32'(mem_be), 32'(m_be));
         if (!m_fetch || e_chk_all) chk("mem_wdata", mem_wdata, m_wdata);
      end
   endtask

   function automatic int pick_wait();
      int r;
      r = $urandom_range(0, 19);
      if (r < 12) return 0;
      if (r < 18) return $urandom_range(1, 4);
      return 30;
   endfunction

   task automatic bus_drive();
      if (mem_req) begin
         if (bus_wait < 0) bus_wait = dir_mode ? dir_wait : pick_wait();
         if (bus_wait == 0) begin
            mem_ack   = 1;
            mem_rdata = dir_mode ? dir_data : $urandom();
            bus_wait  = -1;
         end else begin
            mem_ack   = 0;
            mem_rdata = $urandom();
            bus_wait--;
         end
      end else begin
         bus_wait  = -1;
         mem_ack   = !dir_mode && ($urandom_range(0, 15) == 0);
         mem_rdata = $urandom();
      end
   endtask

   task automatic tick();
      model_eval();
      @(negedge clk);
      check_outputs();
      bus_drive();
   endtask

   task automatic do_reset();
      reset = 1; if_req = 0; dm_req = 0; if_flush = 0;
      tick();
      reset = 0;
      tick();
   endtask

   task automatic rand_reqs();
      if_flush = 0;
      if (reset) reset = 0;
      if ($urandom_range(0, 499) == 0) begin
         reset = 1; if_req = 0; dm_req = 0;
         f_out = 0; d_out = 0;
         return;
      end
      if (f_out && if_ready) f_out = 0;
      if (!f_out) begin
         if ($urandom_range(0, 2) == 0) begin
            f_out   = 1;
            if_req  = 1;
            if_addr = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) if_addr[1:0] = 2'($urandom_range(1, 3));
         end else begin
            if_req = 0;
         end
      end
      if ($urandom_range(0, 11) == 0) begin
         if_flush = 1;
         f_out    = 0;
      end
      if (d_out && dm_ready) d_out = 0;
      if (!d_out) begin
         if ($urandom_range(0, 1) == 0) begin
            d_out    = 1;
            dm_req   = 1;
            dm_we    = 1'($urandom());
            dm_addr  = $urandom() & 32'hFFFF_FFFC;
            dm_wdata = $urandom();
            dm_be    = 4'($urandom());
         end else begin
            dm_req = 0;
         end
      end
   endtask

   initial begin : watchdog
      #1ms;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int  lat, hold, nd_before, nd_after;
      bit  seen, got_if, got_dm, if_after;

      reset = 1; if_req = 0; if_flush = 0; if_addr = 0;
      dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
      mem_ack = 0; mem_rdata = 0;
      dir_mode = 1; dir_wait = 0; dir_data = 0; bus_wait = -1;
      f_out = 0; d_out = 0;

      tick();
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      reset = 0;
      tick();

      // zero-wait fetch
      dir_wait = 0; dir_data = 32'h2408_0001;
      if_req = 1; if_addr = 32'h0000_3000;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         tick(); lat++;
         if (mem_req) chk("fetch_be", 32'(mem_be), 32'hF);
         if (if_ready) break;
      end
      if_req = 0;
      chk("fetch_lat", lat, 2);
      chk("fetch_data", if_rdata, 32'h2408_0001);
      tick();

      // simultaneous data write and fetch: data first
      do_reset();
      dm_req = 1; dm_we = 1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
      dm_be = 4'b0011;
      if_req = 1; if_addr = 32'h0000_3000;
      got_if = 0; got_dm = 0; if_after = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (mem_req && mem_we) begin
            chk("pass_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("pass_be", 32'(mem_be), 32'h3);
         end
         if (dm_ready) begin got_dm = 1; dm_req = 0; end
         if (if_ready) begin got_if = 1; if_req = 0; if_after = got_dm; end
         if (got_if && got_dm) break;
      end
      chk("prio_order", 32'(if_after), 32'h1);

      // anti-starvation with data held continuously
      do_reset();
      dm_req = 1; dm_we = 0; dm_addr = 32'h40; dm_be = 4'hF;
      if_req = 1; if_addr = 32'h0000_3000;
      nd_before = 0; nd_after = 0; got_if = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (dm_ready) begin
            if (got_if) nd_after++;
            else nd_before++;
         end
         if (if_ready) begin got_if = 1; if_req = 0; end
         if (nd_after >= 2) break;
      end
      dm_req = 0;
      chk("starve_data", nd_before, SL);
      chk("starve_resume", nd_after, 2);
      tick();

      // fetch flushed while waiting on a slow ack
      do_reset();
      dir_wait = 5;
      if_req = 1; if_addr = 32'h0000_3100;
      tick();
      chk("flush_rise", 32'(mem_req), 32'h1);
      tick(); tick();
      if_flush = 1;
      tick();
      if_flush = 0; if_req = 0;
      hold = 0; seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (mem_req) hold++;
         if (if_ready) seen = 1;
         tick();
      end
      chk("flush_hold", hold, 3);
      chk("flush_noready", 32'(seen), 32'h0);
      dir_wait = 0; dir_data = 32'h8C09_0004;
      if_req = 1; if_addr = 32'h0000_4180;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         tick(); lat++;
         if (if_ready) break;
      end
      if_req = 0;
      chk("refetch_lat", lat, 2);
      chk("refetch_data", if_rdata, 32'h8C09_0004);

      // data read timeout
      do_reset();
      dir_wait = 1000;
      dm_req = 1; dm_we = 0; dm_addr = 32'h20; dm_be = 4'hF;
      tick();
      chk("tmo_rise", 32'(mem_req), 32'h1);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         tick(); lat++;
         if (dm_ready) break;
      end
      dm_req = 0;
      chk("tmo_lat", lat, TO);
      chk("tmo_err", 32'(dm_err), 32'h1);
      chk("tmo_rdata", dm_rdata, 32'h0);
      chk("tmo_req", 32'(mem_req), 32'h0);

      // misaligned fetch
      do_reset();
      dir_wait = 0;
      if_req = 1; if_addr = 32'h0000_3002;
      lat = 0; seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick(); lat++;
         if (mem_req) seen = 1;
         if (if_ready) break;
      end
      if_req = 0;
      chk("mis_lat", lat, 2);
      chk("mis_err", 32'(if_err), 32'h1);
      chk("mis_noreq", 32'(seen), 32'h0);

      // reset in the middle of a fetch
      do_reset();
      dir_wait = 1000;
      if_req = 1; if_addr = 32'h0000_3000;
      tick();
      chk("rmid_busy", 32'(mem_req), 32'h1);
      tick();
      reset = 1;
      tick();
      reset = 0; if_req = 0;
      chk("rmid_req", 32'(mem_req), 32'h0);
      chk("rmid_addr", mem_addr, 32'h0);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (if_ready || dm_ready) seen = 1;
      end
      chk("rmid_noready", 32'(seen), 32'h0);

      // random traffic
      do_reset();
      dir_mode = 0;
      f_out = 0; d_out = 0;
      for (int c = 0; c < 3000; c++) begin
         rand_reqs();
         tick();
      end
      reset = 0; if_req = 0; dm_req = 0; if_flush = 0;
      for (int i = 0; i < 40; i++) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
